// File: rtl/sram_responder_pkg.sv
// Shared SRAM definitions: latency counter width, default geometry and responder FSM encoding.
package sram_responder_pkg;

   localparam int unsigned SRAM_CNT       = 3;   // width of the read-latency counter
   localparam int unsigned DefaultDepth   = 512;
   localparam int unsigned DefaultReadLat = 2;
   localparam int unsigned SramAddrW      = 17;
   localparam int unsigned SramDataW      = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReadWait,
      StReadDrive
   } sram_state_e;

endpackage

// File: rtl/sram_byte_mem.sv
// DEPTH x 32 word array with upper/lower half-word write enables and an asynchronous read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module sram_byte_mem
   import sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic                 clk_i,
   input  logic                 ub_we_i,
   input  logic                 lb_we_i,
   input  logic [SramAddrW-1:0] waddr_i,
   input  logic [SramDataW-1:0] wdata_i,
   input  logic [SramAddrW-1:0] raddr_i,
   output logic [SramDataW-1:0] rdata_o
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SramDataW-1:0] mem_q [DEPTH];
   logic                 waddr_ok;
   logic                 raddr_ok;
   logic [IdxW-1:0]      widx;
   logic [IdxW-1:0]      ridx;

   assign waddr_ok = 32'(waddr_i) < DEPTH;
   assign raddr_ok = 32'(raddr_i) < DEPTH;
   assign widx     = waddr_i[IdxW-1:0];
   assign ridx     = raddr_i[IdxW-1:0];

   always_ff @(posedge clk_i) begin
      if (waddr_ok) begin
         if (ub_we_i) mem_q[widx][31:16] <= wdata_i[31:16];
         if (lb_we_i) mem_q[widx][15:0]  <= wdata_i[15:0];
      end
   end

   assign rdata_o = raddr_ok ? mem_q[ridx] : '0;

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-SRAM-style responder: byte-lane writes, READ_LAT-edge read latency, tri-state DQ.
// Define SRAM_VIOLATION_CHECK_EN to enable the sticky access_violation detector.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH    = DefaultDepth,
   parameter int unsigned READ_LAT = DefaultReadLat
) (
   input  logic                 clk,
   input  logic                 rst,
   inout  wire  [SramDataW-1:0] SRAM_DQ,
   input  logic [SramAddrW-1:0] SRAM_ADDR,
   input  logic                 SRAM_UB_N,
   input  logic                 SRAM_LB_N,
   input  logic                 SRAM_WE_N,
   input  logic                 SRAM_CE_N,
   input  logic                 SRAM_OE_N,
   output logic                 access_violation
);

   localparam logic [SRAM_CNT-1:0] LatCnt = SRAM_CNT'(READ_LAT);

   sram_state_e          state_q, state_d;
   logic [SRAM_CNT-1:0]  cnt_q, cnt_d;
   logic [SramAddrW-1:0] addr_q, addr_d;
   logic [SramDataW-1:0] dout_q, dout_d;
   logic [SramAddrW-1:0] raddr;
   logic [SramDataW-1:0] rdata;
   logic                 wr_edge;
   logic                 capture;
   logic                 drive_en;

   assign wr_edge = !SRAM_CE_N && !SRAM_WE_N;

   // Only a READ_WAIT completion reads the latched address; captures read the live pins.
   assign raddr = (state_q == StReadWait) ? addr_q : SRAM_ADDR;

   sram_byte_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .ub_we_i (wr_edge && !SRAM_UB_N && !rst),
      .lb_we_i (wr_edge && !SRAM_LB_N && !rst),
      .waddr_i (SRAM_ADDR),
      .wdata_i (SRAM_DQ),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      capture = 1'b0;
      if (wr_edge) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (!SRAM_CE_N) capture = 1'b1;
            end
            StReadWait, StReadDrive: begin
               if (SRAM_CE_N) begin
                  state_d = StIdle;
               end else if (SRAM_ADDR != addr_q) begin
                  capture = 1'b1;
               end else if (state_q == StReadWait) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == LatCnt) begin
                     state_d = StReadDrive;
                     dout_d  = rdata;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
      if (capture) begin
         addr_d = SRAM_ADDR;
         cnt_d  = SRAM_CNT'(1);
         if (READ_LAT == 1) begin
            state_d = StReadDrive;
            dout_d  = rdata;
         end else begin
            state_d = StReadWait;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
      end
   end

   // Release is purely combinational so a falling WE_N never contends with the host.
   assign drive_en = (state_q == StReadDrive) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
   assign SRAM_DQ  = drive_en ? dout_q : 'z;

`ifdef SRAM_VIOLATION_CHECK_EN
   logic viol_q;
   logic viol_hit;

   always_comb begin
      viol_hit = !SRAM_CE_N &&
                 ((32'(SRAM_ADDR) >= DEPTH) ||
                  ((state_q == StReadWait) && ((SRAM_ADDR != addr_q) || !SRAM_WE_N)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         viol_q <= 1'b0;
      end else if (viol_hit) begin
         viol_q <= 1'b1;
      end
   end

   assign access_violation = viol_q;
`else
   assign access_violation = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios with literal expectations, then
// randomized bus traffic compared every cycle against a transaction-level model.
module tb_sram_responder;

   localparam int DEPTH    = 512;
   localparam int READ_LAT = 2;

   logic        clk;
   logic        rst;
   logic        ce_n, we_n, oe_n, ub_n, lb_n;
   logic [16:0] addr;
   logic        tb_drive;
   logic [31:0] tb_data;
   logic        viol;
   tri1  [31:0] dq;

   assign dq = tb_drive ? tb_data : 'z;

   sram_responder #(
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .SRAM_DQ          (dq),
      .SRAM_ADDR        (addr),
      .SRAM_UB_N        (ub_n),
      .SRAM_LB_N        (lb_n),
      .SRAM_WE_N        (we_n),
      .SRAM_CE_N        (ce_n),
      .SRAM_OE_N        (oe_n),
      .access_violation (viol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   // Model: memory contents plus the one outstanding read and its age in edges since capture.
   logic [31:0] m_mem [DEPTH];
   logic        m_active = 1'b0;
   logic [16:0] m_addr   = '0;
   int          m_age    = 0;
   logic [31:0] m_data   = '0;
   logic        m_viol   = 1'b0;

   // Undriven bus floats to all-ones through the pull; stored data keeps bit 31 clear.
   localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_rd(input logic [16:0] a);
      int idx;
      idx = int'(a);
      if (idx < DEPTH) return m_mem[idx];
      return 32'h0;
   endfunction

   function automatic logic [31:0] exp_dq();
      if (tb_drive) return tb_data;
      if (m_active && m_age >= READ_LAT && !ce_n && !oe_n && we_n) return m_data;
      return HIZ;
   endfunction

   task automatic m_edge();
      int idx;
      idx = int'(addr);
      if (rst) begin
         m_active = 1'b0;
         m_viol   = 1'b0;
      end else begin
`ifdef SRAM_VIOLATION_CHECK_EN
         if (!ce_n && (idx >= DEPTH ||
                       (m_active && m_age < READ_LAT && (addr != m_addr || !we_n))))
            m_viol = 1'b1;
`endif
         if (!ce_n && !we_n) begin
            if (idx < DEPTH) begin
               if (!ub_n) m_mem[idx][31:16] = tb_data[31:16];
               if (!lb_n) m_mem[idx][15:0]  = tb_data[15:0];
            end
            m_active = 1'b0;
         end else if (m_active && ce_n) begin
            m_active = 1'b0;
         end else if (!ce_n && (!m_active || addr != m_addr)) begin
            m_active = 1'b1;
            m_addr   = addr;
            m_age    = 1;
            if (m_age >= READ_LAT) m_data = m_rd(addr);
         end else if (m_active && m_age < READ_LAT) begin
            m_age++;
            if (m_age == READ_LAT) m_data = m_rd(m_addr);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      #2;
   endtask

   task automatic set_write(input logic [16:0] a, input logic [31:0] d, input logic u,
                            input logic l);
      ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = u; lb_n = l;
      addr = a; tb_data = d; tb_drive = 1'b1;
   endtask

   task automatic set_read(input logic [16:0] a);
      ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
      addr = a; tb_drive = 1'b0;
   endtask

   function automatic logic [16:0] pick_addr();
      case ($urandom_range(0, 4))
         0:       return 17'($urandom_range(0, 15));
         1:       return 17'($urandom_range(250, 260));
         2:       return 17'($urandom_range(505, 520));
         3:       return 17'(600);
         default: return 17'($urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dq_model", dq, exp_dq());
         chk("viol_model", {31'b0, viol}, {31'b0, m_viol});
      end
   end

   logic exp_v;

   initial begin
      rst = 1'b1; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
      addr = '0; tb_drive = 1'b0; tb_data = '0;
`ifdef SRAM_VIOLATION_CHECK_EN
      exp_v = 1'b1;
`else
      exp_v = 1'b0;
`endif
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("reset_dq_hiz", dq, HIZ);
      chk("reset_viol", {31'b0, viol}, 32'h0);

      for (int i = 0; i < DEPTH; i++) begin
         set_write(17'(i), $urandom & 32'h7FFF_FFFF, 1'b0, 1'b0);
         step();
      end

      // Write 50 @256, read back after exactly two edges.
      set_write(17'd256, 32'd50, 1'b0, 1'b0);
      step();
      set_read(17'd256);
      #1 chk("r256_before", dq, HIZ);
      step();
      #1 chk("r256_edge1", dq, HIZ);
      step();
      #1 chk("r256_edge2", dq, 32'd50);

      // Lower-lane-only overwrite.
      set_write(17'd5, 32'h2ABB_CCDD, 1'b0, 1'b0);
      step();
      set_write(17'd5, 32'h1122_3344, 1'b1, 1'b0);
      step();
      set_read(17'd5);
      step();
      step();
      #1 chk("lane_merge", dq, 32'h2ABB_3344);

      // Address change mid-wait restarts latency.
      set_write(17'd7, 32'h0000_0707, 1'b0, 1'b0);
      step();
      set_write(17'd8, 32'h0000_0808, 1'b0, 1'b0);
      step();
      set_read(17'd7);
      step();
      addr = 17'd8;
      #1 chk("restart_a", dq, HIZ);
      step();
      #1 chk("restart_b", dq, HIZ);
      step();
      #1 chk("restart_data", dq, 32'h0000_0808);

      // WE_N falls during drive: immediate release, write lands, FSM idles.
      set_write(17'd8, 32'h1234_5678, 1'b0, 1'b0);
      #1 chk("we_release", dq, 32'h1234_5678);
      step();
      set_read(17'd8);
      #1 chk("we_idle", dq, HIZ);
      step();
      step();
      #1 chk("we_readback", dq, 32'h1234_5678);

      // Reset mid-read aborts; memory survives.
      set_read(17'd256);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1 chk("rst_abort_dq", dq, HIZ);
      chk("rst_abort_viol", {31'b0, viol}, 32'h0);
      step();
      #1 chk("rst_recapture", dq, HIZ);
      step();
      #1 chk("rst_mem_kept", dq, 32'd50);

      // Out-of-range read returns zero; violation flag depends on build.
      set_read(17'd600);
      step();
      step();
      #1 chk("oor_data", dq, 32'h0);
      chk("oor_viol", {31'b0, viol}, {31'b0, exp_v});
      set_read(17'd3);
      step();
      step();
      #1 chk("viol_sticky", {31'b0, viol}, {31'b0, exp_v});

      for (int n = 0; n < 4000; n++) begin
         rst  = ($urandom_range(0, 199) == 0);
         ce_n = ($urandom_range(0, 9) == 0);
         we_n = ($urandom_range(0, 5) != 0);
         oe_n = ($urandom_range(0, 4) == 0);
         ub_n = 1'($urandom_range(0, 1));
         lb_n = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 3) addr = pick_addr();
         tb_data  = $urandom & 32'h7FFF_FFFF;
         tb_drive = !we_n;
         step();
      end

      rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; tb_drive = 1'b0;
      step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
